// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests and
// buffers returned instructions in a 2-entry queue feeding the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fq_pc_q    [2];
    logic [31:0] fq_pc_d    [2];
    logic [31:0] fq_instr_q [2];
    logic [31:0] fq_instr_d [2];
    logic [31:0] pend_pc_q  [2];
    logic [31:0] pend_pc_d  [2];
    logic [1:0]  count_q, count_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;

    logic        pop, accept, rsp, rsp_keep;
    logic [1:0]  count_after_pop, out_after_rsp;
    logic [2:0]  credit_used;

    always_comb begin
        valid_out       = (count_q != 2'd0);
        pc_out          = valid_out ? fq_pc_q[0] : 32'd0;
        instruction_out = valid_out ? fq_instr_q[0] : NOP_INSTR;
        pop             = valid_out && !stall && !redirect_valid;
        count_after_pop = count_q - {1'b0, pop};
        // Counting the same-cycle pop as free credit keeps 1 instruction/cycle.
        credit_used     = {1'b0, outstanding_q} + {1'b0, count_after_pop};
        imem_req_valid  = !reset && !redirect_valid && (credit_used < 3'd2);
        imem_req_addr   = fetch_pc_q;
        accept          = imem_req_valid && imem_req_ready;
        rsp             = imem_rsp_valid && (outstanding_q != 2'd0);
        rsp_keep        = rsp && (drop_cnt_q == 2'd0);
        out_after_rsp   = outstanding_q - {1'b0, rsp};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fq_pc_d       = fq_pc_q;
        fq_instr_d    = fq_instr_q;
        pend_pc_d     = pend_pc_q;
        count_d       = count_q;
        outstanding_d = out_after_rsp;
        drop_cnt_d    = drop_cnt_q;

        if (rsp) begin
            pend_pc_d[0] = pend_pc_q[1];
        end

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path and is discarded.
            fetch_pc_d = redirect_pc & ~32'd3;
            count_d    = 2'd0;
            drop_cnt_d = out_after_rsp;
        end else begin
            if (accept) begin
                pend_pc_d[out_after_rsp[0]] = fetch_pc_q;
                outstanding_d               = out_after_rsp + 2'd1;
                fetch_pc_d                  = fetch_pc_q + 32'd4;
            end
            if (rsp && (drop_cnt_q != 2'd0)) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end
            if (pop) begin
                fq_pc_d[0]    = fq_pc_q[1];
                fq_instr_d[0] = fq_instr_q[1];
            end
            count_d = count_after_pop;
            if (rsp_keep) begin
                fq_pc_d[count_after_pop[0]]    = pend_pc_q[0];
                fq_instr_d[count_after_pop[0]] = imem_rsp_data;
                count_d                        = count_after_pop + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            fq_pc_q       <= '{default: '0};
            fq_instr_q    <= '{default: '0};
            pend_pc_q     <= '{default: '0};
            count_q       <= 2'd0;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fq_pc_q       <= fq_pc_d;
            fq_instr_q    <= fq_instr_d;
            pend_pc_q     <= pend_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid) begin
            assert (!(rsp_keep && count_after_pop == 2'd2))
                else $error("fetch queue overflow");
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a randomized instruction memory plus a program-order
// model of which PC must be requested next and which PC must be delivered next.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .pc_out(pc_out),
        .instruction_out(instruction_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          after_redirect = 1'b0;
    bit          hold_prev = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr + 32'h0000_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Entered at posedge+1; drives one cycle, checks, updates model, advances.
    task automatic run_cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        int lat;
        int due;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (!valid_out) begin
            chk("empty_instr", instruction_out, NOP_INSTR);
            chk("empty_pc", pc_out, 32'd0);
        end else begin
            chk("head_pc", pc_out, exp_pc);
            chk("head_instr", instruction_out, mem_word(exp_pc));
        end
        if (after_redirect) chk("flush_valid", {31'd0, valid_out}, 32'd0);
        if (hold_prev)      chk("stall_hold", {31'd0, valid_out}, 32'd1);
        if (rd)             chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);

        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (rd) begin
            exp_pc  = rpc & ~32'd3;
            exp_req = rpc & ~32'd3;
        end else begin
            if (valid_out && !st) exp_pc = exp_pc + 32'd4;
            if (imem_req_valid && rdy) begin
                lat = $urandom_range(lat_hi, lat_lo);
                due = cyc + lat;
                if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
                mem_q.push_back('{addr: imem_req_addr, due: due});
                exp_req = exp_req + 32'd4;
                chk("credit_limit", {31'd0, mem_q.size() > 2}, 32'd0);
            end
        end
        after_redirect = rd;
        hold_prev      = valid_out && st && !rd;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        mem_q.delete();
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instr", instruction_out, NOP_INSTR);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_req_valid2", {31'd0, imem_req_valid}, 32'd0);
        reset          = 1'b0;
        exp_pc         = RESET_PC;
        exp_req        = RESET_PC;
        after_redirect = 1'b0;
        hold_prev      = 1'b0;
        cyc            = 0;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (valid_out) seen = 1'b1;
            else run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        // Zero-wait stream, then a 5-cycle stall starting at cycle 4.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 16; i++) begin
            chk("first_valid_timing", {31'd0, valid_out}, {31'd0, cyc >= 2});
            if (cyc == 2) chk("first_pc", pc_out, RESET_PC);
            if (cyc == 4) chk("stall_head_pc", pc_out, 32'h8);
            run_cycle(cyc >= 4 && cyc <= 8, 1'b0, 32'd0, 1'b1);
        end

        // Ready held low for 4 cycles while requesting 0x10.
        do_reset(1);
        for (int i = 0; i < 30 && exp_req != 32'h10; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("reach_0x10", exp_req, 32'h10);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
            chk("ready_low_addr", imem_req_addr, 32'h10);
        end
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Latency 3: redirect with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("two_outstanding", mem_q.size(), 32'd2);
        run_cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        wait_valid("redir_deliver");
        chk("redir_target_pc", pc_out, 32'h0000_0100);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect in the same cycle as a response, with stall asserted.
        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 10 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); i++)
            run_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        run_cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1);
        wait_valid("coinc_deliver");
        chk("coinc_target_pc", pc_out, 32'h0000_2000);

        // Address wrap at the top of the address space.
        run_cycle(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom,
                      $urandom_range(99) < 70);
        end

        // Reset in the middle of a latency-3 stream.
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        do_reset(1);
        lat_lo = 1; lat_hi = 3;
        chk("restart_addr", imem_req_addr, RESET_PC);
        for (int i = 0; i < 40; i++) run_cycle($urandom_range(99) < 20, 1'b0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a 2-entry fetch queue. The queue head drives the IF/ID pipeline register's `pc_in` and `instruction_in`. Branch/jump redirects from EX flush the stage. A downstream stall holds the head.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): value driven on `instruction_out` when `valid_out` = 0.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: downstream cannot accept; head is not consumed this cycle.
- `redirect_valid` in 1: EX redirect request; highest priority.
- `redirect_pc` in 32: new fetch address; bits [1:0] are forced to 0 internally.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address (the fetch PC).
- `imem_rsp_valid` in 1: response valid. Responses are in order, with latency ≥ 1 cycle after acceptance.
- `imem_rsp_data` in 32: fetched instruction.
- `pc_out` out 32: PC of the queue head, or 0 when the queue is empty.
- `instruction_out` out 32: instruction at the queue head, or `NOP_INSTR` when the queue is empty.
- `valid_out` out 1: queue is non-empty.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - Fetch queue: 2 entries of {pc, instr}, with `count` 0..2.
  - Pending-PC queue: 2 entries holding the PC of each outstanding request.
  - `outstanding` 0..2.
  - `drop_cnt` 0..2.
- Pop: occurs when `valid_out && !stall`.
- Issue condition: `imem_req_valid` = `!redirect_valid && (outstanding + count - pop) < 2`. This includes the combinational pop term and is required to sustain 1 instruction/cycle.
- Request accept (`imem_req_valid && imem_req_ready`):
  - push `fetch_pc` into the pending-PC queue;
  - `outstanding` += 1;
  - `fetch_pc` += 4 (32-bit wrap: 32'hFFFF_FFFC → 0).
- While `imem_req_valid` = 1 and `imem_req_ready` = 0, `imem_req_addr` holds stable.
- Response (`imem_rsp_valid` with `outstanding` > 0):
  - `outstanding` -= 1;
  - pop the pending-PC queue;
  - if `drop_cnt` > 0, decrement `drop_cnt` and discard the data;
  - otherwise push {pending pc, `imem_rsp_data`} into the fetch queue.
- Response with `outstanding` = 0: ignored.
- Credit guarantees the fetch queue never overflows. A push into a full queue is impossible by construction; an assertion flags it.
- Redirect (`redirect_valid` = 1), regardless of `stall`:
  - fetch queue cleared (`count` = 0, so `valid_out` = 0 next cycle);
  - `fetch_pc` <= `redirect_pc` & ~3;
  - `drop_cnt` <= `outstanding` minus 1 if a response arrives this same cycle (that response is itself discarded);
  - no request is issued this cycle;
  - no pop is counted.
- Simultaneous push and pop on a 1-entry queue: `count` is unchanged, and the new entry becomes head on the next cycle.
- Reset result: `fetch_pc` = `RESET_PC`, `count` = 0, `outstanding` = 0, `drop_cnt` = 0, both queues emptied. Reset mid-operation abandons all in-flight requests; instruction memory is reset by the same `reset`.

## Timing
- Reset values of outputs:
  - `valid_out` = 0, `pc_out` = 0, `instruction_out` = `NOP_INSTR`;
  - `imem_req_valid` = 0 while `reset` = 1;
  - `imem_req_addr` = `RESET_PC`.
- First request: cycle 0 after `reset` deasserts, addressing `RESET_PC`.
- With zero-wait memory (ready = 1, response 1 cycle after accept):
  - request accepted at cycle N;
  - response at N+1;
  - `valid_out` = 1 with that PC at N+2.
- Steady state with no stall: 1 instruction/cycle.
- Redirect at cycle R with zero-wait memory:
  - `valid_out` = 0 at R+1;
  - first request to the target at R+1;
  - target instruction at the head at R+3.
- Stall: head outputs hold stable. At most 2 instructions are buffered; further issue stops until a pop.

## Test plan
- Reset release with zero-wait memory returning 32'h0000_0093 + 4·k for address 4k, no stall → `valid_out` at cycle 2, then `pc_out` = 0, 4, 8, … one per cycle with matching instructions.
- `stall` held 5 cycles from cycle 4 → head (pc 8) stable, `count` reaches 2, no requests beyond the credit limit. Release → pc 12, 16 follow with no gap or duplicate.
- Redirect to 32'h0000_0103 while 2 requests are outstanding (memory latency 3) → both old responses dropped, `valid_out` = 0 at R+1, next delivered `pc_out` = 32'h0000_0100.
- `imem_req_ready` low for 4 cycles at pc 32'h10 → `imem_req_addr` holds 32'h10, no duplicate fetch, and the stream resumes in order.
- Redirect coincident with a response and with `stall` = 1 → response discarded, queue flushed, and the target is fetched.
- Assert `reset` mid-stream with 2 outstanding → next cycle `valid_out` = 0 and `imem_req_valid` = 0. After release, fetch restarts at `RESET_PC`.
